// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the boot-time instruction loader.
//            Holds the loader state encoding, default geometry and the width
//            of the HOLD interval counter.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Default instruction-memory geometry
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  // HOLD_CYC is limited to 1..255, so an 8-bit down-counter covers it
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } loader_state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/loader_hold_ctr.sv
`default_nettype none
// ============================================================================
// Module   : loader_hold_ctr
// Purpose  : Loadable down-counter with a zero flag; times the interval the
//            core is kept in reset after the final instruction write.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            i_load     - load i_load_val (has priority over i_dec)
//            i_load_val - value to load
//            i_dec      - decrement by one, saturating at zero
//            o_zero     - counter value is zero
// Revision : 1.0 - initial release
// ============================================================================
module loader_hold_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_zero = w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_cnt <= r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule : loader_hold_ctr
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time program loader. Accepts instruction words on a
//            valid/ready stream, writes them into instruction memory, holds
//            the core in reset while loading and releases it HOLD_CYC cycles
//            after the final write.
// Options  : IMEM_LOADER_CKSUM_EN - when defined, a trailer word follows the
//            program; the load only completes if sum(words)+trailer == 0
//            (modulo 2^DATA_W), otherwise err is raised and the core stays
//            in reset.
// Ports    : clk, rst_n           - clock / async active-low reset
//            start, len          - begin a load of len words (1..2^ADDR_W)
//            s_valid/s_data      - input word stream, s_ready back-pressure
//            mem_we/addr/wdata   - instruction-memory write port
//            core_rst_n          - active-low reset to the core
//            busy, done, err     - status (LOAD/HOLD, RUN entry pulse, sticky)
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   c_len_max  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_len_one  = {{ADDR_W{1'b0}}, 1'b1};
  // The counter is loaded with HOLD_CYC-1 and RUN is entered on the cycle it
  // reads zero, giving exactly HOLD_CYC cycles in HOLD.
  localparam logic [HOLD_W-1:0] c_hold_init = HOLD_W'(HOLD_CYC - 1);

  loader_state_t     r_state, w_state_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_core_rst_n, w_core_rst_n_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;

  logic              w_ready;
  logic              w_hs;
  logic              w_len_ok;
  logic              w_hold_load;
  logic              w_hold_dec;
  logic              w_hold_zero;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [DATA_W-1:0] r_sum, w_sum_nxt;
  logic [DATA_W-1:0] w_sum_chk;
  assign w_sum_chk = r_sum + s_data;
`endif

  assign w_ready  = (r_state == ST_LOAD);
  assign w_hs     = s_valid & w_ready;
  assign w_len_ok = (len != '0) && (len <= c_len_max);

  assign s_ready    = w_ready;
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_HOLD);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign done       = r_done;
  assign err        = r_err;

  loader_hold_ctr #(
    .WIDTH (HOLD_W)
  ) u_hold_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_hold_load),
    .i_load_val (c_hold_init),
    .i_dec      (w_hold_dec),
    .o_zero     (w_hold_zero)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = 1'b0;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_core_rst_n_nxt = r_core_rst_n;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;
    w_count_nxt      = r_count;
    w_len_nxt        = r_len;
    w_hold_load      = 1'b0;
    w_hold_dec       = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    w_sum_nxt        = r_sum;
`endif

    case (r_state)
      ST_IDLE, ST_RUN: begin
        // A start from RUN is a reload: the core goes back into reset
        if (start) begin
          if (w_len_ok) begin
            w_state_nxt      = ST_LOAD;
            w_len_nxt        = len;
            w_count_nxt      = '0;
            w_err_nxt        = 1'b0;
            w_core_rst_n_nxt = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            w_sum_nxt        = '0;
`endif
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (w_hs) begin
`ifdef IMEM_LOADER_CKSUM_EN
          if (r_count == r_len) begin
            // Trailer word: checked, never written to memory
            if (w_sum_chk == '0) begin
              w_state_nxt = ST_HOLD;
              w_hold_load = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_err_nxt   = 1'b1;
            end
          end else begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_count[ADDR_W-1:0];
            w_wdata_nxt = s_data;
            w_count_nxt = r_count + c_len_one;
            w_sum_nxt   = w_sum_chk;
          end
`else
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_count[ADDR_W-1:0];
          w_wdata_nxt = s_data;
          w_count_nxt = r_count + c_len_one;
          if (r_count == (r_len - c_len_one)) begin
            w_state_nxt = ST_HOLD;
            w_hold_load = 1'b1;
          end
`endif
        end
      end

      ST_HOLD: begin
        if (w_hold_zero) begin
          w_state_nxt      = ST_RUN;
          w_core_rst_n_nxt = 1'b1;
          w_done_nxt       = 1'b1;
        end else begin
          w_hold_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
      r_len        <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_count      <= w_count_nxt;
      r_len        <= w_len_nxt;
`ifdef IMEM_LOADER_CKSUM_EN
      r_sum        <= w_sum_nxt;
`endif
    end
  end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader (ADDR_W=8,
//            DATA_W=32, HOLD_CYC=4). Inputs change 1 ns after the rising
//            edge; outputs are sampled at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int HOLD_CYC = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] tb_sum;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and check it lands in memory one cycle later
  task automatic send_word(input logic [DATA_W-1:0] w, input logic [ADDR_W-1:0] a);
    s_valid = 1'b1;
    s_data  = w;
    tick();
    tb_sum = tb_sum + w;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a, w}) begin
      n_fail++;
      $display("FAIL write: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
               mem_we, mem_addr, mem_wdata, a, w);
    end
  endtask

  // From the cycle after the last data handshake: optional trailer, then the
  // HOLD interval while an extra word is offered and must not be taken.
  task automatic finish_hold();
`ifdef IMEM_LOADER_CKSUM_EN
    s_valid = 1'b1;
    s_data  = -tb_sum;
    tick();
    n_checks++;
    if ({mem_we, s_ready, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL trailer: got we=%b rdy=%b busy=%b want 0 0 1", mem_we, s_ready, busy);
    end
`endif
    s_valid = 1'b1;
    s_data  = 32'h5A5A_5A5A;
    for (int k = 1; k <= HOLD_CYC; k++) begin
      tick();
      n_checks++;
      if (k < HOLD_CYC) begin
        if ({done, core_rst_n, busy, mem_we, s_ready} !== 5'b00100) begin
          n_fail++;
          $display("FAIL hold%0d: got done=%b crst=%b busy=%b we=%b rdy=%b want 0 0 1 0 0",
                   k, done, core_rst_n, busy, mem_we, s_ready);
        end
      end else begin
        if ({done, core_rst_n, busy, mem_we, s_ready} !== 5'b11000) begin
          n_fail++;
          $display("FAIL run_entry: got done=%b crst=%b busy=%b we=%b rdy=%b want 1 1 0 0 0",
                   done, core_rst_n, busy, mem_we, s_ready);
        end
      end
    end
    s_valid = 1'b0;
    tick();
    n_checks++;
    if ({done, core_rst_n, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL run_steady: got done=%b crst=%b busy=%b want 0 1 0", done, core_rst_n, busy);
    end
  endtask

  task automatic start_load(input logic [ADDR_W:0] n);
    start  = 1'b1;
    len    = n;
    tick();
    start  = 1'b0;
    tb_sum = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    #3;
    n_checks++;
    if ({core_rst_n, s_ready, mem_we, err, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset: got crst=%b rdy=%b we=%b err=%b busy=%b done=%b want all 0",
               core_rst_n, s_ready, mem_we, err, busy, done);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({core_rst_n, s_ready, busy, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got crst=%b rdy=%b busy=%b addr=%0d data=%h want all 0",
               core_rst_n, s_ready, busy, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_basic_load();
    logic [DATA_W-1:0] w [3];
    w[0] = 32'h0050_0093; w[1] = 32'h00A0_0113; w[2] = 32'h0020_81B3;
    // s_valid together with start must not be accepted
    s_valid = 1'b1;
    s_data  = w[0];
    start_load(9'd3);
    n_checks++;
    if ({mem_we, s_ready, busy, core_rst_n} !== 4'b0110) begin
      n_fail++;
      $display("FAIL basic_start: got we=%b rdy=%b busy=%b crst=%b want 0 1 1 0",
               mem_we, s_ready, busy, core_rst_n);
    end
    for (int i = 0; i < 3; i++) send_word(w[i], ADDR_W'(i));
    finish_hold();
  endtask

  task automatic test_backpressure();
    logic [3:0] vld;
    logic [3:0] exp_we;
    logic [ADDR_W-1:0] exp_a [4];
    logic [DATA_W-1:0] exp_d [4];
    vld    = 4'b1001;   // bit i = cycle i
    exp_we = 4'b1001;
    exp_a[0] = 8'd0; exp_a[1] = 8'd0; exp_a[2] = 8'd0; exp_a[3] = 8'd1;
    exp_d[0] = 32'h1111_1111; exp_d[1] = 32'h1111_1111;
    exp_d[2] = 32'h1111_1111; exp_d[3] = 32'h2222_2222;
    // Started from RUN: this is also a reload
    s_valid = 1'b0;
    start_load(9'd2);
    n_checks++;
    if ({core_rst_n, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_reload: got crst=%b busy=%b want 0 1", core_rst_n, busy);
    end
    for (int i = 0; i < 4; i++) begin
      s_valid = vld[i];
      s_data  = (i == 0) ? 32'h1111_1111 : (i == 3) ? 32'h2222_2222 : 32'hDEAD_0000;
      tick();
      if (vld[i]) tb_sum = tb_sum + s_data;
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {exp_we[i], exp_a[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                 i, mem_we, mem_addr, mem_wdata, exp_we[i], exp_a[i], exp_d[i]);
      end
    end
    finish_hold();
  endtask

  task automatic test_illegal_len();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    start_load(9'd0);
    tick();
    n_checks++;
    if ({err, busy, s_ready, core_rst_n} !== 4'b1000) begin
      n_fail++;
      $display("FAIL len0: got err=%b busy=%b rdy=%b crst=%b want 1 0 0 0",
               err, busy, s_ready, core_rst_n);
    end
    start_load(9'd257);
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL len257: got err=%b busy=%b want 1 0", err, busy);
    end
    start_load(9'd1);
    n_checks++;
    if ({err, busy, s_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b busy=%b rdy=%b want 0 1 1", err, busy, s_ready);
    end
    send_word(32'hDEAD_BEEF, 8'd0);
    finish_hold();
  endtask

  task automatic test_reload();
    start_load(9'd0);
    n_checks++;
    if ({err, core_rst_n, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL run_illegal: got err=%b crst=%b busy=%b want 1 1 0", err, core_rst_n, busy);
    end
    start_load(9'd1);
    n_checks++;
    if ({err, core_rst_n, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL reload: got err=%b crst=%b busy=%b want 0 0 1", err, core_rst_n, busy);
    end
    send_word(32'hCAFE_F00D, 8'd0);
    finish_hold();
  endtask

  task automatic test_midload_reset();
    start_load(9'd3);
    send_word(32'h1234_5678, 8'd0);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #2;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, core_rst_n, done, err, s_ready, busy} !== '0) begin
      n_fail++;
      $display("FAIL midload_rst: got we=%b addr=%0d data=%h crst=%b done=%b err=%b rdy=%b busy=%b want all 0",
               mem_we, mem_addr, mem_wdata, core_rst_n, done, err, s_ready, busy);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, core_rst_n, mem_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL midload_idle: got busy=%b crst=%b we=%b want 0 0 0", busy, core_rst_n, mem_we);
    end
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  task automatic test_cksum();
    // Good trailer: 1 + 2 + 0xFFFFFFFD == 0; finish_hold sends -tb_sum
    start_load(9'd2);
    send_word(32'd1, 8'd0);
    send_word(32'd2, 8'd1);
    n_checks++;
    if (-tb_sum !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL cksum_model: got %h want fffffffd", -tb_sum);
    end
    finish_hold();
    // Bad trailer
    start_load(9'd2);
    send_word(32'd1, 8'd0);
    send_word(32'd2, 8'd1);
    s_valid = 1'b1;
    s_data  = 32'd0;
    tick();
    s_valid = 1'b0;
    n_checks++;
    if ({err, busy, core_rst_n, mem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL cksum_bad: got err=%b busy=%b crst=%b we=%b want 1 0 0 0",
               err, busy, core_rst_n, mem_we);
    end
    for (int k = 0; k < HOLD_CYC + 2; k++) tick();
    n_checks++;
    if ({done, core_rst_n, err} !== 3'b001) begin
      n_fail++;
      $display("FAIL cksum_stay: got done=%b crst=%b err=%b want 0 0 1", done, core_rst_n, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_illegal_len();
    test_reload();
    test_midload_reset();
`ifdef IMEM_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
